// File: rtl/grad_ingress_arbiter.sv
// grad_ingress_arbiter
//   Round-robin ingress arbiter for gradient beats. NUM_REQ requesters offer
//   (address, signed gradient) beats. One beat per cycle is granted into a
//   single output register that feeds the streamer/accumulator. A flush
//   request drains the output register, starts the accumulator flush,
//   waits for completion and acknowledges it. Arbitration then resumes
//   with the round-robin pointer it had before the flush.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   src_valid/ready     per-requester handshake (src_ready one-hot or zero)
//   src_addr/src_grad   packed per-requester data, requester i at slice i
//   out_valid/ready     output register handshake
//   out_addr/grad/src   registered beat and the ID of its requester
//   flush_req           level request to flush the accumulator
//   flush_start         one-cycle pulse that starts the accumulator flush
//   flush_done          accumulator flush finished (honoured only in FLUSH)
//   flush_ack           one-cycle pulse marking flush completion
//   busy                high whenever the block is not arbitrating
module grad_ingress_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      src_valid,
    input  logic [NUM_REQ*32-1:0]   src_addr,
    input  logic [NUM_REQ*16-1:0]   src_grad,
    output logic [NUM_REQ-1:0]      src_ready,
    output logic                    out_valid,
    output logic [31:0]             out_addr,
    output logic signed [15:0]      out_grad,
    output logic [SRC_W-1:0]        out_src,
    input  logic                    out_ready,
    input  logic                    flush_req,
    output logic                    flush_start,
    input  logic                    flush_done,
    output logic                    flush_ack,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_DRAIN,
        ST_FLUSH,
        ST_ACK
    } state_t;

    state_t              r_state;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic                r_out_valid;
    logic [31:0]         r_out_addr;
    logic signed [15:0]  r_out_grad;
    logic [SRC_W-1:0]    r_out_src;
    logic                r_flush_start;
    logic                r_flush_ack;

    logic [31:0]         w_addr [NUM_REQ];
    logic [15:0]         w_grad [NUM_REQ];
    logic [SRC_W-1:0]    w_scan_idx;
    logic [SRC_W-1:0]    w_grant_idx;
    logic                w_grant_any;
    logic                w_can_load;
    logic                w_grant_en;
    logic                w_src_fire;
    logic [NUM_REQ-1:0]  w_grant;
    logic [SRC_W-1:0]    w_ptr_next;
    logic                w_out_held;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_addr[i] = src_addr[32*i +: 32];
            w_grad[i] = src_grad[16*i +: 16];
        end
    end

    // First valid requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        w_scan_idx  = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = SRC_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_grant_any && src_valid[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_can_load = !r_out_valid || out_ready;
    // rst_n keeps src_ready low while reset is held, since the grant is
    // otherwise a combinational function of src_valid.
    assign w_grant_en = (r_state == ST_ARB) && !flush_req && w_can_load && rst_n;
    assign w_src_fire = w_grant_en && w_grant_any;

    always_comb begin
        w_grant = '0;
        if (w_src_fire) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + SRC_W'(1);
    // Output register still occupied after this edge (no load is possible
    // outside ARB, so only draining changes it).
    assign w_out_held = r_out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ARB;
            r_rr_ptr      <= '0;
            r_out_valid   <= 1'b0;
            r_out_addr    <= '0;
            r_out_grad    <= '0;
            r_out_src     <= '0;
            r_flush_start <= 1'b0;
            r_flush_ack   <= 1'b0;
        end else begin
            r_flush_start <= 1'b0;
            r_flush_ack   <= 1'b0;

            if (w_src_fire) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= w_addr[w_grant_idx];
                r_out_grad  <= w_grad[w_grant_idx];
                r_out_src   <= w_grant_idx;
                r_rr_ptr    <= w_ptr_next;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // flush_start is registered so that it is high during exactly the
            // DRAIN cycle in which the output register is empty; that cycle is
            // predicted one edge early from the drain condition.
            case (r_state)
                ST_ARB: begin
                    if (flush_req) begin
                        r_state <= ST_DRAIN;
                        if (!w_out_held) begin
                            r_flush_start <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!r_out_valid) begin
                        r_state <= ST_FLUSH;
                    end else if (out_ready) begin
                        r_flush_start <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        r_state     <= ST_ACK;
                        r_flush_ack <= 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!flush_req) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    assign src_ready   = w_grant;
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_grad    = r_out_grad;
    assign out_src     = r_out_src;
    assign flush_start = r_flush_start;
    assign flush_ack   = r_flush_ack;
    assign busy        = (r_state != ST_ARB);

endmodule

// File: tb/tb_grad_ingress_arbiter.sv
// Testbench for grad_ingress_arbiter (NUM_REQ = 4). A queue-based reference
// model predicts grants, the output register and the flush handshake. The
// model's expectations are compared with the DUT every cycle at the falling
// edge, and directed steps add explicit checks on top of that.
module tb_grad_ingress_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         src_valid;
    logic [N*32-1:0]      src_addr;
    logic [N*16-1:0]      src_grad;
    logic [N-1:0]         src_ready;
    logic                 out_valid;
    logic [31:0]          out_addr;
    logic signed [15:0]   out_grad;
    logic [SW-1:0]        out_src;
    logic                 out_ready;
    logic                 flush_req;
    logic                 flush_start;
    logic                 flush_done;
    logic                 flush_ack;
    logic                 busy;

    always #5 clk = ~clk;

    grad_ingress_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_addr   (src_addr),
        .src_grad   (src_grad),
        .src_ready  (src_ready),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_grad   (out_grad),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .flush_req  (flush_req),
        .flush_start(flush_start),
        .flush_done (flush_done),
        .flush_ack  (flush_ack),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] g;
        int          s;
    } beat_t;

    // Reference model state
    beat_t m_held[$];
    string m_mode;
    int    m_ptr;
    int    m_ack_age;

    // Stimulus policy: 1 = requester re-offers a fresh beat after acceptance
    bit keep_valid = 1'b1;

    // DUT values captured at the last check point
    logic [N-1:0]  s_ready;
    logic [SW-1:0] s_src;
    logic [31:0]   s_addr;
    logic [15:0]   s_grad;
    logic          s_outv, s_fs, s_fa, s_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held.delete();
        m_mode    = "ARB";
        m_ptr     = 0;
        m_ack_age = 0;
    endtask

    function automatic int model_grant();
        if (!rst_n || m_mode != "ARB" || flush_req) return -1;
        if (m_held.size() != 0 && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (src_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_beat(input int i, input logic v);
        src_valid[i]        = v;
        src_addr[32*i +: 32] = $urandom;
        src_grad[16*i +: 16] = 16'($urandom);
    endtask

    task automatic check_all();
        int           g;
        logic [N-1:0] er;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("src_ready", src_ready, er);
        chk("out_valid", out_valid, m_held.size() != 0);
        if (m_held.size() != 0) begin
            chk("out_addr", out_addr, m_held[0].a);
            chk("out_grad", $unsigned(out_grad), m_held[0].g);
            chk("out_src", out_src, m_held[0].s);
        end
        chk("flush_start", flush_start, (m_mode == "DRAIN") && (m_held.size() == 0));
        chk("flush_ack", flush_ack, (m_mode == "ACK") && (m_ack_age == 0));
        chk("busy", busy, m_mode != "ARB");
        s_ready = src_ready;
        s_src   = out_src;
        s_addr  = out_addr;
        s_grad  = out_grad;
        s_outv  = out_valid;
        s_fs    = flush_start;
        s_fa    = flush_ack;
        s_busy  = busy;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step(output int g);
        bit    was_empty;
        beat_t b;
        g = -1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        g         = model_grant();
        was_empty = (m_held.size() == 0);
        if (!was_empty && out_ready) void'(m_held.pop_front());
        if (g >= 0) begin
            b.a = src_addr[32*g +: 32];
            b.g = src_grad[16*g +: 16];
            b.s = g;
            m_held.push_back(b);
            m_ptr = (g + 1) % N;
        end
        if (m_mode == "ARB") begin
            if (flush_req) m_mode = "DRAIN";
        end else if (m_mode == "DRAIN") begin
            if (was_empty) m_mode = "FLUSH";
        end else if (m_mode == "FLUSH") begin
            if (flush_done) begin
                m_mode    = "ACK";
                m_ack_age = 0;
            end
        end else begin
            m_ack_age++;
            if (!flush_req) m_mode = "ARB";
        end
    endtask

    task automatic cycle();
        int g;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step(g);
        #1;
        if (g >= 0) set_beat(g, keep_valid ? 1'b1 : 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int           saved_ptr;
        int           c_fs, c_ack, fs_cnt, ack_cnt;
        logic [N-1:0] e;
        logic [31:0]  sa;
        logic [15:0]  sg;

        // ---- reset values ----
        rst_n      = 1'b1;
        src_valid  = '0;
        src_addr   = '0;
        src_grad   = '0;
        out_ready  = 1'b0;
        flush_req  = 1'b0;
        flush_done = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) set_beat(i, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_src_ready", src_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_grad", $unsigned(out_grad), 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_flush_start", flush_start, 0);
        chk("rst_flush_ack", flush_ack, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst_n = 1'b1;

        // ---- all requesters valid, out_ready=1: grants 0,1,2,3,0,... ----
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            e = 4'b0001 << (k % 4);
            chk("rr_grant", s_ready, e);
            if (k > 0) chk("rr_out_src", s_src, (k - 1) % 4);
        end

        // ---- reset with a beat held discards it ----
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", out_valid, 0);
        chk("rst_drop_busy", busy, 0);
        model_reset();
        src_valid = '0;
        set_beat(1, 1'b1);
        cycle();
        rst_n = 1'b1;

        // ---- src_valid=1010 with rr_ptr=2: grants 3,1,3 ----
        cycle();
        chk("ptr_setup_grant1", s_ready, 4'b0010);
        set_beat(3, 1'b1);
        cycle();
        chk("sparse_grant3a", s_ready, 4'b1000);
        cycle();
        chk("sparse_grant1", s_ready, 4'b0010);
        cycle();
        chk("sparse_grant3b", s_ready, 4'b1000);

        // ---- backpressure for 5 cycles ----
        set_beat(0, 1'b1);
        set_beat(2, 1'b1);
        out_ready = 1'b0;
        sa = m_held[0].a;
        sg = m_held[0].g;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_ready", s_ready, 0);
            chk("stall_valid", s_outv, 1);
            chk("stall_addr", s_addr, sa);
            chk("stall_grad", s_grad, sg);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        // ---- flush with a held beat, flush_done 4 cycles after flush_start ----
        saved_ptr = m_ptr;
        c_fs      = -1;
        c_ack     = -1;
        fs_cnt    = 0;
        ack_cnt   = 0;
        for (int c = 0; c < 14; c++) begin
            out_ready  = (c >= 3);
            flush_done = (c_fs >= 0) && (c == c_fs + 4);
            flush_req  = !((c_ack >= 0) && (c >= c_ack + 2));
            cycle();
            if (s_fs) begin
                fs_cnt++;
                if (c_fs < 0) c_fs = c;
            end
            if (s_fa) begin
                ack_cnt++;
                if (c_ack < 0) c_ack = c;
            end
            if (c == 0) chk("flush_no_grant", s_ready, 0);
            if (c >= 1 && c <= 3) chk("drain_holds_beat", s_outv, 1);
            if (c >= 1 && c <= 4) chk("drain_busy", s_busy, 1);
            if (c == 12) begin
                e = '0;
                e[saved_ptr] = 1'b1;
                chk("resume_ptr", s_ready, e);
                chk("idle_busy", s_busy, 0);
            end
        end
        chk("flush_start_count", fs_cnt, 1);
        chk("flush_start_cycle", c_fs, 4);
        chk("flush_ack_count", ack_cnt, 1);
        chk("flush_ack_cycle", c_ack, 9);
        flush_done = 1'b0;

        // ---- reset asserted while in FLUSH ----
        flush_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (m_mode == "FLUSH") break;
        end
        flush_done = 1'b1;
        @(negedge clk);
        chk("in_flush_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstf_src_ready", src_ready, 0);
        chk("rstf_out_valid", out_valid, 0);
        chk("rstf_out_addr", out_addr, 0);
        chk("rstf_out_grad", $unsigned(out_grad), 0);
        chk("rstf_out_src", out_src, 0);
        chk("rstf_flush_start", flush_start, 0);
        chk("rstf_flush_ack", flush_ack, 0);
        chk("rstf_busy", busy, 0);
        model_reset();
        flush_req = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("rstf_no_ack", s_fa, 0);
        end
        rst_n      = 1'b1;
        flush_done = 1'b0;

        // ---- randomized traffic with random flushes ----
        keep_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            flush_req  = ($urandom_range(0, 24) == 0) ? 1'b1
                                                      : (flush_req && ($urandom_range(0, 3) != 0));
            flush_done = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!src_valid[i] && ($urandom_range(0, 1) == 1)) set_beat(i, 1'b1);
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
